// File: rtl/adder_tree_sched.sv
// Round-robin scheduler that feeds one shared adder_tree from N_CHAN channels and tags each sum with its channel.
// Latency: out_valid/out_chan/out_result appear LATENCY+1 edges after the accepting edge; ADDER_TREE_SCHED_STATS_EN adds grant_count.
// Backpressure: one grant per cycle through req_ready; no output backpressure; flush stops grants and drains in-flight sums.
module adder_tree_sched #(
  parameter int N_CHAN       = 4,
  parameter int N            = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int LATENCY      = $clog2(N),
  parameter int RESULT_WIDTH = DATA_WIDTH + $clog2(N) + (((N > 1) && ((N & (N - 1)) == 0)) ? 1 : 0)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [N_CHAN-1:0]              req_valid,
  output logic [N_CHAN-1:0]              req_ready,
  input  logic [N_CHAN*N*DATA_WIDTH-1:0] req_data,
  output logic [N*DATA_WIDTH-1:0]        tree_data,
  input  logic [RESULT_WIDTH-1:0]        tree_result,
  input  logic                           flush,
  output logic                           flush_done,
  output logic                           out_valid,
  output logic [$clog2(N_CHAN)-1:0]      out_chan,
  output logic [RESULT_WIDTH-1:0]        out_result
`ifdef ADDER_TREE_SCHED_STATS_EN
  ,
  output logic [N_CHAN*16-1:0]           grant_count
`endif
);

  localparam int CW = $clog2(N_CHAN);
  localparam int VW = N * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic          vld;
    logic [CW-1:0] chan;
  } tag_t;

  state_t               state;
  logic [CW-1:0]        last_grant;
  tag_t [LATENCY:0]     tag_pipe;
  logic                 flush_hold;

  logic [N_CHAN-1:0]    grant;
  logic [CW-1:0]        grant_idx;
  logic [CW-1:0]        cand;
  logic                 found;
  logic                 can_grant;
  logic                 xfer;
  logic                 pipe_empty;

  // First requester after last_grant, wrapping modulo N_CHAN.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int i = 1; i <= N_CHAN; i++) begin
      cand = CW'((int'(last_grant) + i) % N_CHAN);
      if (!found && req_valid[cand]) begin
        found           = 1'b1;
        grant_idx       = cand;
        grant[cand]     = 1'b1;
      end
    end
  end

  assign can_grant = !reset && !flush && (state != DRAIN);
  assign req_ready = can_grant ? grant : '0;
  assign xfer      = can_grant && found;

  always_comb begin
    pipe_empty = 1'b1;
    for (int k = 0; k <= LATENCY; k++) begin
      if (tag_pipe[k].vld) pipe_empty = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= CW'(N_CHAN - 1);
      tag_pipe   <= '0;
      flush_hold <= 1'b0;
      tree_data  <= '0;
      out_valid  <= 1'b0;
      out_chan   <= '0;
      out_result <= '0;
      flush_done <= 1'b0;
    end else begin
      flush_done       <= 1'b0;
      tag_pipe[0].vld  <= xfer;
      tag_pipe[0].chan <= grant_idx;
      for (int k = 1; k <= LATENCY; k++) begin
        tag_pipe[k] <= tag_pipe[k-1];
      end
      out_valid <= tag_pipe[LATENCY].vld;
      // Only load on a live tag so a discarded or idle tree output never leaks out.
      if (tag_pipe[LATENCY].vld) begin
        out_chan   <= tag_pipe[LATENCY].chan;
        out_result <= tree_result;
      end
      if (xfer) begin
        tree_data  <= req_data[grant_idx*VW +: VW];
        last_grant <= grant_idx;
      end

      case (state)
        IDLE: begin
          if (!flush) begin
            flush_hold <= 1'b0;
            if (xfer) state <= RUN;
          end else if (!flush_hold) begin
            if (pipe_empty) begin
              flush_done <= 1'b1;
              flush_hold <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        RUN: begin
          if (flush) begin
            if (pipe_empty) begin
              state      <= IDLE;
              flush_done <= 1'b1;
              flush_hold <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else if (!xfer && pipe_empty) begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (pipe_empty) begin
            state      <= IDLE;
            flush_done <= 1'b1;
            flush_hold <= flush;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADDER_TREE_SCHED_STATS_EN
  logic [N_CHAN-1:0][15:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (xfer && (cnt[grant_idx] != 16'hFFFF)) begin
      cnt[grant_idx] <= cnt[grant_idx] + 16'd1;
    end
  end

  assign grant_count = cnt;
`endif

endmodule

// File: tb/tb_adder_tree_sched.sv
// Randomized and directed bench for adder_tree_sched with a behavioural adder tree and a queue scoreboard.
module tb_adder_tree_sched;

  localparam int NC  = 4;
  localparam int N   = 8;
  localparam int DW  = 16;
  localparam int LAT = 3;
  localparam int RW  = 20;
  localparam int CW  = 2;

  logic                   clock;
  logic                   reset;
  logic [NC-1:0]          req_valid;
  logic [NC-1:0]          req_ready;
  logic [NC*N*DW-1:0]     req_data;
  logic [N*DW-1:0]        tree_data;
  logic [RW-1:0]          tree_result;
  logic                   flush;
  logic                   flush_done;
  logic                   out_valid;
  logic [CW-1:0]          out_chan;
  logic [RW-1:0]          out_result;
`ifdef ADDER_TREE_SCHED_STATS_EN
  logic [NC*16-1:0]       grant_count;
`endif

  adder_tree_sched #(
    .N_CHAN(NC), .N(N), .DATA_WIDTH(DW), .LATENCY(LAT), .RESULT_WIDTH(RW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data(req_data),
    .tree_data(tree_data),
    .tree_result(tree_result),
    .flush(flush),
    .flush_done(flush_done),
    .out_valid(out_valid),
    .out_chan(out_chan),
    .out_result(out_result)
`ifdef ADDER_TREE_SCHED_STATS_EN
    ,
    .grant_count(grant_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Stand-in adder tree: LAT register stages after tree_data.
  logic signed [RW-1:0] tpipe [LAT];
  int tsum;
  always @(posedge clock) begin
    tsum = 0;
    for (int j = 0; j < N; j++) tsum += int'($signed(tree_data[j*DW +: DW]));
    tpipe[0] <= RW'(tsum);
    for (int k = 1; k < LAT; k++) tpipe[k] <= tpipe[k-1];
  end
  assign tree_result = tpipe[LAT-1];

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard and round-robin reference.
  int  q_due[$];
  int  q_chan[$];
  int  q_sum[$];
  int  m_last = NC - 1;
  bit  blocked = 1'b0;
  int  out_cnt = 0;
  int  g, c, s, e_due, e_chan, e_sum;
  logic [NC-1:0] exp_rdy;

  always @(negedge clock) begin
    if (out_valid === 1'b1) begin
      check(q_chan.size() > 0, "out_unexpected", out_chan, -1);
      if (q_chan.size() > 0) begin
        e_due  = q_due.pop_front();
        e_chan = q_chan.pop_front();
        e_sum  = q_sum.pop_front();
        check(cyc == e_due, "out_latency", cyc, e_due);
        check(int'(out_chan) == e_chan, "out_chan", out_chan, e_chan);
        check(int'($signed(out_result)) == e_sum, "out_result", int'($signed(out_result)), e_sum);
      end
      out_cnt++;
    end
    g = -1;
    if (!reset && !blocked) begin
      for (int i = 1; i <= NC; i++) begin
        c = (m_last + i) % NC;
        if (g < 0 && req_valid[c]) g = c;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check(req_ready === exp_rdy, "req_ready", req_ready, exp_rdy);
    if (g >= 0) begin
      s = 0;
      for (int j = 0; j < N; j++) s += int'($signed(req_data[(g*N+j)*DW +: DW]));
      // Accepted at the coming edge (cyc+1), visible LAT+1 edges later.
      q_due.push_back(cyc + 1 + LAT + 1);
      q_chan.push_back(g);
      q_sum.push_back(s);
      m_last = g;
    end
    if (reset) begin
      q_due.delete();
      q_chan.delete();
      q_sum.delete();
      m_last = NC - 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_all(input int ch, input logic [DW-1:0] v);
    for (int j = 0; j < N; j++) req_data[(ch*N+j)*DW +: DW] = v;
  endtask

  task automatic rand_data();
    for (int j = 0; j < NC*N; j++) req_data[j*DW +: DW] = DW'($urandom);
  endtask

  task automatic summary();
    $display("%0d/%0d checks passed", n_pass, n_total);
  endtask

  initial begin
    #3000000;
    check(1'b0, "watchdog", cyc, -1);
    summary();
    $fatal(1, "watchdog expired");
  end

  int  cnt0;
  bit  got;
  int  pulses;

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    flush     = 1'b0;
    repeat (3) tick();
    check(req_ready == '0, "reset_ready", req_ready, 0);
    check(out_valid == 1'b0, "reset_out_valid", out_valid, 0);
    check(out_chan == '0, "reset_out_chan", out_chan, 0);
    check(out_result == '0, "reset_out_result", out_result, 0);
    check(tree_data == '0, "reset_tree_data", tree_data, 0);
    check(flush_done == 1'b0, "reset_flush_done", flush_done, 0);
    reset = 1'b0;

    // Single request on ch2, all samples 1.
    set_all(2, 16'd1);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    repeat (8) tick();

    // All channels continuously valid.
    req_valid = 4'b1111;
    repeat (12) begin rand_data(); tick(); end
    req_valid = '0;
    repeat (8) tick();

    // Signed extremes on ch0.
    set_all(0, 16'h8000);
    req_valid = 4'b0001;
    tick();
    set_all(0, 16'h7FFF);
    tick();
    req_valid = '0;
    repeat (8) tick();

    // Random traffic.
    repeat (300) begin
      rand_data();
      req_valid = NC'($urandom);
      tick();
    end
    req_valid = '0;
    repeat (8) tick();

    // Flush during a full-rate stream; valid stays high to test flush priority.
    req_valid = 4'b1111;
    repeat (8) begin rand_data(); tick(); end
    flush   = 1'b1;
    blocked = 1'b1;
    #1;
    check(req_ready == '0, "flush_ready_same_cycle", req_ready, 0);
    @(negedge clock);
    #1;
    cnt0 = out_cnt;
    got  = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clock);
      #1;
      if (flush_done) got = 1'b1;
    end
    check(got, "flush_done_seen", got, 1);
    check(out_cnt - cnt0 == 4, "flush_drain_results", out_cnt - cnt0, 4);
    pulses = got ? 1 : 0;
    repeat (4) begin
      @(negedge clock);
      #1;
      if (flush_done) pulses++;
    end
    check(pulses == 1, "flush_done_pulses", pulses, 1);
    tick();
    flush   = 1'b0;
    blocked = 1'b0;
    repeat (4) tick();
    req_valid = '0;
    repeat (8) tick();

    // Flush while idle with an empty pipeline.
    flush   = 1'b1;
    blocked = 1'b1;
    @(negedge clock);
    check(flush_done == 1'b0, "idle_flush_before_edge", flush_done, 0);
    @(negedge clock);
    check(flush_done == 1'b1, "idle_flush_done_next", flush_done, 1);
    pulses = 0;
    req_valid = 4'b1010;
    repeat (4) begin
      @(negedge clock);
      if (flush_done) pulses++;
    end
    check(pulses == 0, "idle_flush_hold_no_repulse", pulses, 0);
    tick();
    flush   = 1'b0;
    blocked = 1'b0;
    tick();
    req_valid = '0;
    repeat (8) tick();

    // Reset with three ch1 sums in flight.
    rand_data();
    req_valid = 4'b0010;
    repeat (3) tick();
    req_valid = '0;
    reset     = 1'b1;
    cnt0      = out_cnt;
    repeat (2) tick();
    reset = 1'b0;
    repeat (8) tick();
    check(out_cnt == cnt0, "reset_discard", out_cnt - cnt0, 0);
    check(out_valid == 1'b0, "post_reset_out_valid", out_valid, 0);
    check(out_chan == '0, "post_reset_out_chan", out_chan, 0);
    check(out_result == '0, "post_reset_out_result", out_result, 0);
    check(tree_data == '0, "post_reset_tree_data", tree_data, 0);
    check(flush_done == 1'b0, "post_reset_flush_done", flush_done, 0);
    req_valid = 4'b1111;
    #1;
    check(req_ready == 4'b0001, "post_reset_first_grant", req_ready, 1);
    tick();
    req_valid = '0;
    repeat (8) tick();

`ifdef ADDER_TREE_SCHED_STATS_EN
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check(grant_count == '0, "stats_reset", grant_count, 0);
    req_valid = 4'b0010;
    repeat (10) tick();
    req_valid = '0;
    check(grant_count[16 +: 16] == 16'd10, "stats_ch1", grant_count[16 +: 16], 10);
    check(grant_count[0 +: 16] == 16'd0, "stats_ch0", grant_count[0 +: 16], 0);
    check(grant_count[32 +: 16] == 16'd0, "stats_ch2", grant_count[32 +: 16], 0);
    check(grant_count[48 +: 16] == 16'd0, "stats_ch3", grant_count[48 +: 16], 0);
    req_valid = 4'b0010;
    repeat (65525) tick();
    req_valid = '0;
    check(grant_count[16 +: 16] == 16'hFFFF, "stats_reach_max", grant_count[16 +: 16], 65535);
    req_valid = 4'b0010;
    repeat (5) tick();
    req_valid = '0;
    check(grant_count[16 +: 16] == 16'hFFFF, "stats_saturate", grant_count[16 +: 16], 65535);
    repeat (8) tick();
`endif

    repeat (4) tick();
    check(q_chan.size() == 0, "scoreboard_drained", q_chan.size(), 0);
    summary();
    $finish;
  end

endmodule

// File: doc/adder_tree_sched.md
ADDER_TREE_SCHED -- requirements
Module: adder_tree_sched

Interface
REQ-001 SHALL have parameter N_CHAN, default 4, the number of requesting channels sharing one adder_tree.
REQ-002 SHALL have parameter N, default 8, the number of samples per request vector (the tree's N).
REQ-003 SHALL have parameter DATA_WIDTH, default 16, the signed sample width.
REQ-004 SHALL have parameter LATENCY, default $clog2(N), the number of register stages in the shared tree.
REQ-005 SHALL have parameter RESULT_WIDTH, default DATA_WIDTH+$clog2(N) (+1 if N is a power of two and N>1 overflows), matching the tree's result width.
REQ-006 SHALL have clock, input, 1 bit: the single clock; all logic rising-edge.
REQ-007 SHALL have reset, input, 1 bit: synchronous, active-high.
REQ-008 SHALL have req_valid, input, N_CHAN bits: per-channel request valid.
REQ-009 SHALL have req_ready, output, N_CHAN bits: per-channel accept (one-hot or zero).
REQ-010 SHALL have req_data, input, N_CHAN*N*DATA_WIDTH bits: channel c's vector at [c*N*DATA_WIDTH +: N*DATA_WIDTH].
REQ-011 SHALL have tree_data, output, N*DATA_WIDTH bits: registered vector driven to the tree's data input.
REQ-012 SHALL have tree_result, input, RESULT_WIDTH bits: the tree's signed result.
REQ-013 SHALL have flush, input, 1 bit: a level request to stop granting and drain.
REQ-014 SHALL have flush_done, output, 1 bit: a one-cycle pulse when the drain completes.
REQ-015 SHALL have out_valid, output, 1 bit; out_chan, output, $clog2(N_CHAN) bits; and out_result, output, RESULT_WIDTH bits: the tagged sum.

Function
REQ-016 SHALL grant round-robin: the first channel with req_valid high, searching from last_grant+1 modulo N_CHAN; req_ready SHALL be combinational from req_valid and state.
REQ-017 SHALL accept at most one request per cycle; a transfer SHALL occur when req_valid[c] and req_ready[c] are both high at a rising edge.
REQ-018 SHALL update last_grant only on a transfer.
REQ-019 SHALL load tree_data with the accepted vector at the accepting edge; tree_data SHALL hold its value when no transfer occurs.
REQ-020 SHALL carry the valid bit and channel tag in a LATENCY+1 deep shift register alongside the tree.
REQ-021 SHALL register out_result (from tree_result), out_chan and out_valid so that out_valid is high for exactly one cycle, LATENCY+1 edges after the accepting edge.
REQ-022 SHALL provide no backpressure on the output: a result is produced every cycle a grant occurred LATENCY+1 cycles earlier, and a full-rate stream SHALL be sustained.
REQ-023 SHALL implement an FSM with states IDLE, RUN and DRAIN.
REQ-024 SHALL go IDLE->RUN on any transfer.
REQ-025 SHALL go RUN->IDLE when the tag pipeline is empty and there is no transfer.
REQ-026 SHALL go IDLE/RUN->DRAIN when flush is high.
REQ-027 SHALL hold req_ready at all zeros in DRAIN.
REQ-028 SHALL go DRAIN->IDLE on the first cycle the tag pipeline is empty, pulsing flush_done in that cycle.
REQ-029 SHALL give flush priority over a simultaneous req_valid: no grant that cycle.
REQ-030 SHALL, on flush while IDLE with an empty pipeline, pulse flush_done on the next cycle.
REQ-031 SHALL, if flush is still high after flush_done, remain in IDLE with no grants until flush falls.

Reset
REQ-032 SHALL, at reset, clear last_grant to N_CHAN-1 (channel 0 wins first), set state IDLE, clear the tag pipeline, and zero tree_data, out_valid, out_chan, out_result and flush_done.
REQ-033 SHALL hold req_ready at zero while reset is high.
REQ-034 SHALL discard in-flight sums on reset mid-operation: no out_valid for them after reset.

Configuration
REQ-035 SHALL, with macro ADDER_TREE_SCHED_STATS_EN defined, add output grant_count (N_CHAN*16 bits: per-channel saturating transfer counters, cleared by reset).
REQ-036 SHALL, with ADDER_TREE_SCHED_STATS_EN undefined, omit the grant_count port and its logic.

Verification (N_CHAN=4, N=8, DATA_WIDTH=16, LATENCY=3, real adder_tree attached)
REQ-037 SHALL cover a single channel: ch2 valid once with all samples=1 -> out_valid exactly 4 cycles after acceptance, out_chan=2, out_result=8.
REQ-038 SHALL cover all four channels continuously valid -> grants 0,1,2,3,0,... one per cycle, with back-to-back out_valid in the same order.
REQ-039 SHALL cover signed extremes: all samples -32768 -> out_result=-262144; all samples 32767 -> out_result=262136.
REQ-040 SHALL cover flush during a full-rate stream -> req_ready=0 the same cycle, exactly 4 further results, then flush_done pulses once and state returns to IDLE.
REQ-041 SHALL cover reset asserted with 3 sums in flight -> no out_valid afterward, the next grant goes to ch0, and all outputs are zero.
REQ-042 SHALL cover the stats build: 10 transfers on ch1 -> grant_count[ch1]=10, other channels 0; a counter preloaded at 65535 stays at 65535.
